// File: rtl/decode_unglue.sv
// Byte-granular request decoder over a 32-bit framed FIFO stream.
// Frames are unpacked into an 8-byte MSB-first buffer and served as 1..4 byte responses.
module decode_unglue #(
  parameter int ENDIAN_SWAP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [33:0] fifo_dout,
  input  logic        fifo_empty,
  input  logic        fifo_valid,
  output logic        fifo_rd_en,
  input  logic        src_done,
  input  logic        req_valid,
  input  logic [2:0]  req_len,
  output logic        req_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_len,
  output logic        out_valid,
  output logic        out_last,
  output logic [3:0]  byte_count,
  output logic        stream_done
);

  function automatic logic [2:0] frame_bytes(input logic [1:0] mask);
    case (mask)
      2'b00:   frame_bytes = 3'd4;
      2'b01:   frame_bytes = 3'd1;
      2'b10:   frame_bytes = 3'd2;
      2'b11:   frame_bytes = 3'd3;
      default: frame_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    keep_bytes = 32'h0000_0000;
      3'd1:    keep_bytes = d & 32'hFF00_0000;
      3'd2:    keep_bytes = d & 32'hFFFF_0000;
      3'd3:    keep_bytes = d & 32'hFFFF_FF00;
      default: keep_bytes = d;
    endcase
  endfunction

  function automatic logic [31:0] byte_rev(input logic [31:0] d, input logic [2:0] n);
    case (n)
      3'd0:    byte_rev = 32'h0000_0000;
      3'd1:    byte_rev = {d[31:24], 24'h00_0000};
      3'd2:    byte_rev = {d[23:16], d[31:24], 16'h0000};
      3'd3:    byte_rev = {d[15:8], d[23:16], d[31:24], 8'h00};
      default: byte_rev = {d[7:0], d[15:8], d[23:16], d[31:24]};
    endcase
  endfunction

  logic [63:0] buf_r, buf_s;
  logic [3:0]  count_r, count_s, rem_s;
  logic        pending_r, pending_s;
  logic        eos_r, eos_s;
  logic [2:0]  len_s, take_s, nbytes_s;
  logic        accept_s, append_s, done_s, last_s;
  logic        fifo_rd_en_s, req_ready_s;
  logic [31:0] taken_s, resp_data_s;
  logic [31:0] out_data_r;
  logic [2:0]  out_len_r;
  logic        out_valid_r, out_last_r, stream_done_r;

  // Request length normalisation: 0 stays 0, oversize requests clamp to a word
  always_comb begin
    len_s = req_len;
    if (req_len == 3'd0) begin
      len_s = 3'd0;
    end else if (req_len > 3'd4) begin
      len_s = 3'd4;
    end else begin
      len_s = req_len;
    end
  end

  // Handshake strobes; a drained stream stalls every further request
  always_comb begin
    done_s       = eos_r && !pending_r && (count_r == 4'd0);
    fifo_rd_en_s = 1'b0;
    req_ready_s  = 1'b0;
    if (rst) begin
      fifo_rd_en_s = 1'b0;
      req_ready_s  = 1'b0;
    end else begin
      fifo_rd_en_s = !fifo_empty && !pending_r && !eos_r && (count_r <= 4'd4);
      req_ready_s  = !done_s && ((count_r >= {1'b0, len_s}) ||
                                 (eos_r && !pending_r && (count_r != 4'd0)));
    end
  end

  // Buffer next state: consume from the top, append behind the survivors
  always_comb begin
    accept_s = req_valid && req_ready_s;
    append_s = fifo_valid && pending_r;
    nbytes_s = frame_bytes(fifo_dout[33:32]);
    take_s   = 3'd0;
    if (accept_s) begin
      take_s = ({1'b0, len_s} < count_r) ? len_s : count_r[2:0];
    end else begin
      take_s = 3'd0;
    end
    rem_s = count_r - {1'b0, take_s};
    buf_s = buf_r << {take_s, 3'b000};
    count_s = rem_s;
    if (append_s) begin
      buf_s   = buf_s | ({keep_bytes(fifo_dout[31:0], nbytes_s), 32'h0000_0000} >> {rem_s, 3'b000});
      count_s = rem_s + {1'b0, nbytes_s};
    end else begin
      count_s = rem_s;
    end
    pending_s = pending_r;
    if (fifo_rd_en_s) begin
      pending_s = 1'b1;
    end else if (fifo_valid) begin
      pending_s = 1'b0;
    end else begin
      pending_s = pending_r;
    end
    eos_s = eos_r || (append_s && (fifo_dout[33:32] != 2'b00)) ||
            (src_done && fifo_empty && !pending_r);
    taken_s = keep_bytes(buf_r[63:32], take_s);
    resp_data_s = (ENDIAN_SWAP != 0) ? byte_rev(taken_s, take_s) : taken_s;
    last_s = eos_r && !pending_r && (rem_s == 4'd0);
  end

  // State and registered response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r         <= 64'h0;
      count_r       <= 4'd0;
      pending_r     <= 1'b0;
      eos_r         <= 1'b0;
      out_data_r    <= 32'h0;
      out_len_r     <= 3'd0;
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      stream_done_r <= 1'b0;
    end else begin
      buf_r         <= buf_s;
      count_r       <= count_s;
      pending_r     <= pending_s;
      eos_r         <= eos_s;
      out_data_r    <= resp_data_s;
      out_len_r     <= take_s;
      out_valid_r   <= accept_s && (len_s != 3'd0);
      out_last_r    <= accept_s && (len_s != 3'd0) && last_s;
      stream_done_r <= eos_s && !pending_s && (count_s == 4'd0);
    end
  end

  assign fifo_rd_en  = fifo_rd_en_s;
  assign req_ready   = req_ready_s;
  assign out_data    = out_data_r;
  assign out_len     = out_len_r;
  assign out_valid   = out_valid_r;
  assign out_last    = out_last_r;
  assign byte_count  = count_r;
  assign stream_done = stream_done_r;

endmodule

// File: tb/tb_decode_unglue.sv
// Scoreboard bench for decode_unglue: a FIFO model feeds two instances (MSB-first and
// byte-swapped); expected responses are derived from the pushed byte stream.
module tb_decode_unglue;

  logic        clk = 1'b0;
  logic        rst, fifo_empty, fifo_valid, src_done, req_valid;
  logic [33:0] fifo_dout;
  logic [2:0]  req_len;
  logic        fifo_rd_en, req_ready, out_valid, out_last, stream_done;
  logic [31:0] out_data;
  logic [2:0]  out_len;
  logic [3:0]  byte_count;
  logic        s_fifo_rd_en, s_req_ready, s_out_valid, s_out_last, s_stream_done;
  logic [31:0] s_out_data;
  logic [2:0]  s_out_len;
  logic [3:0]  s_byte_count;

  always #5 clk = ~clk;

  decode_unglue #(.ENDIAN_SWAP(0)) u_dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_valid(fifo_valid), .fifo_rd_en(fifo_rd_en), .src_done(src_done),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .out_data(out_data), .out_len(out_len), .out_valid(out_valid),
    .out_last(out_last), .byte_count(byte_count), .stream_done(stream_done));

  decode_unglue #(.ENDIAN_SWAP(1)) u_swap (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_valid(fifo_valid), .fifo_rd_en(s_fifo_rd_en), .src_done(src_done),
    .req_valid(req_valid), .req_len(req_len), .req_ready(s_req_ready),
    .out_data(s_out_data), .out_len(s_out_len), .out_valid(s_out_valid),
    .out_last(s_out_last), .byte_count(s_byte_count), .stream_done(s_stream_done));

  typedef struct {
    logic [31:0] data;
    logic [2:0]  len;
    logic        last;
  } resp_t;

  int          checks = 0;
  int          failures = 0;
  resp_t       sb[$];
  logic [33:0] fq[$];
  logic [7:0]  exp_bytes[$];
  logic        final_q;
  logic        rd_s, acc_s, due_s;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rev_bytes(input logic [31:0] d, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < n; i++) r[31-8*i -: 8] = d[31-8*(n-1-i) -: 8];
    return r;
  endfunction

  task automatic model_take(input logic [2:0] rl);
    int          n;
    resp_t       r;
    logic [31:0] d;
    n = (rl > 3'd4) ? 4 : int'(rl);
    if (n > exp_bytes.size()) n = exp_bytes.size();
    d = 32'h0;
    for (int i = 0; i < n; i++) d[31-8*i -: 8] = exp_bytes.pop_front();
    r.data = d;
    r.len  = 3'(n);
    r.last = final_q && (exp_bytes.size() == 0);
    if (rl != 3'd0) sb.push_back(r);
  endtask

  // One clock: sample handshakes, check the response, then advance the FIFO model
  task automatic cycle();
    resp_t r;
    #1;
    rd_s  = fifo_rd_en;
    acc_s = req_valid && req_ready;
    due_s = 1'b0;
    if (acc_s && !rst) begin
      due_s = (req_len != 3'd0);
      model_take(req_len);
    end
    @(posedge clk);
    #1;
    if (!rst && (due_s || out_valid)) begin
      check_eq("out_valid", out_valid, due_s);
      if (out_valid && due_s && sb.size() > 0) begin
        r = sb.pop_front();
        check_eq("out_data", out_data, r.data);
        check_eq("out_len", out_len, r.len);
        check_eq("out_last", out_last, r.last);
        check_eq("swap_valid", s_out_valid, 1);
        check_eq("swap_data", s_out_data, rev_bytes(r.data, int'(r.len)));
      end
    end
    @(negedge clk);
    if (rd_s && fq.size() > 0) begin
      fifo_valid = 1'b1;
      fifo_dout  = fq.pop_front();
    end else begin
      fifo_valid = 1'b0;
    end
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push_frame(input logic [1:0] mask, input logic [31:0] data);
    int nb;
    fq.push_back({mask, data});
    fifo_empty = 1'b0;
    nb = (mask == 2'b00) ? 4 : int'(mask);
    for (int i = 0; i < nb; i++) exp_bytes.push_back(data[31-8*i -: 8]);
    if (mask != 2'b00) final_q = 1'b1;
  endtask

  task automatic req(input logic [2:0] len);
    logic got;
    got = 1'b0;
    req_valid = 1'b1;
    req_len = len;
    for (int i = 0; i < 60 && !got; i++) begin
      cycle();
      got = acc_s;
    end
    req_valid = 1'b0;
    check_eq("req_accept", got, 1);
  endtask

  task automatic wait_count(input logic [3:0] n);
    for (int i = 0; i < 60 && byte_count != n; i++) cycle();
    check_eq("byte_count", byte_count, n);
  endtask

  task automatic do_reset(input logic stale);
    rst = 1'b1; req_valid = 1'b1; req_len = 3'd4; fifo_empty = 1'b0;
    fifo_valid = 1'b0; src_done = 1'b0; final_q = 1'b0;
    fq.delete(); exp_bytes.delete(); sb.delete();
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_len", out_len, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_byte_count", byte_count, 0);
    check_eq("rst_stream_done", stream_done, 0);
    check_eq("rst_fifo_rd_en", fifo_rd_en, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_swap_count", s_byte_count, 0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; fifo_empty = 1'b1;
    if (stale) begin
      fifo_valid = 1'b1;
      fifo_dout = {2'b00, 32'hDEAD_BEEF};
      cycle();
      check_eq("stale_ignored", byte_count, 0);
    end
  endtask

  initial begin
    rst = 1'b1; fifo_empty = 1'b1; fifo_valid = 1'b0; src_done = 1'b0;
    req_valid = 1'b0; req_len = 3'd0; fifo_dout = 34'h0; final_q = 1'b0;
    rd_s = 1'b0; acc_s = 1'b0; due_s = 1'b0;
    @(negedge clk);
    do_reset(1'b0);

    // Basic unpacking, zero-length and oversize requests
    req(3'd0);
    push_frame(2'b00, 32'h1122_3344);
    push_frame(2'b00, 32'h5566_7788);
    req(3'd3); req(3'd3); req(3'd2);
    push_frame(2'b00, 32'h99AA_BBCC);
    req(3'd7);

    // Read throttling while the buffer holds more than a word
    push_frame(2'b00, 32'hA0A1_A2A3);
    push_frame(2'b00, 32'hB0B1_B2B3);
    push_frame(2'b00, 32'hC0C1_C2C3);
    wait_count(4'd8);
    req(3'd3);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_eq("rd_en_held", rd_s, 0);
    end
    check_eq("count_five", byte_count, 5);
    req(3'd1);
    cycle();
    check_eq("rd_en_resume", rd_s, 1);
    req(3'd4); req(3'd4);

    // Source finished with a partial buffer
    do_reset(1'b0);
    push_frame(2'b00, 32'h1122_3344);
    req(3'd1);
    src_done = 1'b1;
    final_q = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    req(3'd4);
    cycle();
    check_eq("done_partial", stream_done, 1);
    req_valid = 1'b1; req_len = 3'd1;
    cycle();
    check_eq("stall_after_done", acc_s, 0);
    req_valid = 1'b0;

    // Short final frame
    do_reset(1'b0);
    push_frame(2'b00, 32'h0102_0304);
    push_frame(2'b10, 32'hAABB_0000);
    req(3'd4); req(3'd4);
    cycle();
    check_eq("done_final", stream_done, 1);

    // Reset mid-stream with a stale fifo_valid afterwards
    do_reset(1'b0);
    push_frame(2'b00, 32'h0A0B_0C0D);
    push_frame(2'b00, 32'h1A1B_1C1D);
    wait_count(4'd8);
    req(3'd2);
    check_eq("count_six", byte_count, 6);
    req(3'd1);
    do_reset(1'b1);
    push_frame(2'b00, 32'h1122_3344);
    req(3'd4);
    check_eq("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
